tc_pcie_symbol_aligner: RTL and testbench



---
 rtl/tc_pcie_symbol_aligner_if.sv | 21 ++
 rtl/tc_pcie_symbol_aligner.sv | 144 ++++++++++++++
 tb/tb_tc_pcie_symbol_aligner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tc_pcie_symbol_aligner_if.sv
// Stream bundle between the RX width converter, the symbol aligner and the 8b/10b decoder.
// The slave modport is the aligner's view; the master modport is the upstream/downstream side.
interface tc_pcie_symbol_aligner_if;
  logic [79:0] rxdata_i;
  logic        rxvalid_i;
  logic [79:0] rxdata_o;
  logic        rxvalid_o;
  logic [7:0]  comma_o;
  logic        aligned_o;
  logic [3:0]  offset_o;

  modport master (
    output rxdata_i, rxvalid_i,
    input  rxdata_o, rxvalid_o, comma_o, aligned_o, offset_o
  );

  modport slave (
    input  rxdata_i, rxvalid_i,
    output rxdata_o, rxvalid_o, comma_o, aligned_o, offset_o
  );
endinterface

// File: rtl/tc_pcie_symbol_aligner.sv
// K28.5 comma search across all ten bit offsets of a 160-bit window with a lock/unlock
// state machine; emits symbol-aligned 80-bit words and per-symbol comma flags.
module tc_pcie_symbol_aligner #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input logic                          rxclk_i,
  input logic                          reset_i,
  tc_pcie_symbol_aligner_if.slave      bus
);

  localparam logic [9:0] K28_5_NEG = 10'h17C;
  localparam logic [9:0] K28_5_POS = 10'h283;
  localparam logic [3:0] LOCK_C    = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C  = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    CHECK     = 2'd1,
    ALIGNED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [79:0] prev_q, prev_d;
  logic [79:0] rxdata_q, rxdata_d;
  logic [7:0]  comma_q, comma_d;
  logic        rxvalid_q, rxvalid_d;
  logic        aligned_q, aligned_d;
  logic [3:0]  offset_q, offset_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  err_cnt_q, err_cnt_d;

  logic [159:0] window;
  logic [159:0] shifted;
  logic [7:0]   match [10];
  logic [9:0]   hit;
  logic         comma_found;
  logic         hit_cur;
  logic [3:0]   found_off;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    window      = {bus.rxdata_i, prev_q};
    shifted     = window >> offset_q;
    found_off   = 4'd0;
    for (int k = 0; k < 10; k++) begin
      for (int n = 0; n < 8; n++) begin
        match[k][n] = (window[k+10*n +: 10] == K28_5_NEG) ||
                      (window[k+10*n +: 10] == K28_5_POS);
      end
      hit[k] = |match[k];
    end
    // Scan downward so the lowest hit offset wins.
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) found_off = 4'(k);
    end
    comma_found = |hit;
    hit_cur     = hit[offset_q];
  end

  always_comb begin
    prev_d      = prev_q;
    rxdata_d    = rxdata_q;
    comma_d     = comma_q;
    rxvalid_d   = 1'b0;
    state_d     = state_q;
    offset_d    = offset_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (bus.rxvalid_i) begin
      prev_d    = bus.rxdata_i;
      rxdata_d  = shifted[79:0];
      comma_d   = match[offset_q];
      rxvalid_d = 1'b1;
      if (comma_found) begin
        unique case (state_q)
          UNALIGNED: begin
            offset_d    = found_off;
            match_cnt_d = 4'd1;
            state_d     = (LOCK_C == 4'd1) ? ALIGNED : CHECK;
          end
          CHECK: begin
            if (hit_cur) begin
              match_cnt_d = sat_inc(match_cnt_q);
              if (match_cnt_d >= LOCK_C) state_d = ALIGNED;
            end else begin
              offset_d    = found_off;
              match_cnt_d = 4'd1;
            end
          end
          ALIGNED: begin
            if (hit_cur) begin
              err_cnt_d = 4'd0;
            end else begin
              err_cnt_d = sat_inc(err_cnt_q);
              // Dropping lock keeps the old offset; the next comma word re-seeds it.
              if (err_cnt_d >= UNLOCK_C) begin
                state_d     = UNALIGNED;
                err_cnt_d   = 4'd0;
                match_cnt_d = 4'd0;
              end
            end
          end
          default: state_d = UNALIGNED;
        endcase
      end
    end
    aligned_d = (state_d == ALIGNED);
  end

  always_ff @(posedge rxclk_i) begin
    if (reset_i) begin
      state_q     <= UNALIGNED;
      prev_q      <= '0;
      rxdata_q    <= '0;
      comma_q     <= '0;
      rxvalid_q   <= 1'b0;
      aligned_q   <= 1'b0;
      offset_q    <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      rxdata_q    <= rxdata_d;
      comma_q     <= comma_d;
      rxvalid_q   <= rxvalid_d;
      aligned_q   <= aligned_d;
      offset_q    <= offset_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.rxdata_o  = rxdata_q;
  assign bus.rxvalid_o = rxvalid_q;
  assign bus.comma_o   = comma_q;
  assign bus.aligned_o = aligned_q;
  assign bus.offset_o  = offset_q;

endmodule

// File: tb/tb_tc_pcie_symbol_aligner.sv
// Directed, table-driven bench for tc_pcie_symbol_aligner: reset, lock, mixed disparity,
// re-seed in CHECK, loss of lock, gaps and mid-stream reset.
module tb_tc_pcie_symbol_aligner;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [79:0] din;
    logic        ev;
    logic [79:0] ed;
    logic [7:0]  ec;
    logic        ea;
    logic [3:0]  eo;
  } vec_t;

  localparam logic [79:0] C3 = 80'h17C << 3;
  localparam logic [79:0] C6 = 80'h17C << 6;
  localparam logic [79:0] C7 = 80'h17C << 7;
  localparam logic [79:0] S5 = 80'h283 << 50;
  localparam logic [79:0] Z  = 80'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  tc_pcie_symbol_aligner_if bus ();

  tc_pcie_symbol_aligner #(.LOCK_CNT(3), .UNLOCK_CNT(4)) dut (
    .rxclk_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic v, input logic [79:0] d, input logic ev,
                        input logic [79:0] ed, input logic [7:0] ec, input logic ea,
                        input logic [3:0] eo);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.ev = ev; t.ed = ed; t.ec = ec; t.ea = ea; t.eo = eo;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [79:0] ed,
                             input logic [7:0] ec, input logic ea, input logic [3:0] eo);
    checks += 5;
    if (bus.rxvalid_o !== ev) begin
      failures++;
      $display("[TB] FAIL %s rxvalid_o got=%b exp=%b", tag, bus.rxvalid_o, ev);
    end
    if (bus.rxdata_o !== ed) begin
      failures++;
      $display("[TB] FAIL %s rxdata_o got=%h exp=%h", tag, bus.rxdata_o, ed);
    end
    if (bus.comma_o !== ec) begin
      failures++;
      $display("[TB] FAIL %s comma_o got=%h exp=%h", tag, bus.comma_o, ec);
    end
    if (bus.aligned_o !== ea) begin
      failures++;
      $display("[TB] FAIL %s aligned_o got=%b exp=%b", tag, bus.aligned_o, ea);
    end
    if (bus.offset_o !== eo) begin
      failures++;
      $display("[TB] FAIL %s offset_o got=%0d exp=%0d", tag, bus.offset_o, eo);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [79:0] d);
    @(negedge clk);
    rst           = r;
    bus.rxvalid_i = v;
    bus.rxdata_i  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rxvalid_i = 1'b1;
    bus.rxdata_i  = '0;

    // Lock at offset 3; the comma is seen one word late because it sits in prev.
    addVec(0, 1, C3, 1, Z,            8'h00, 0, 4'd0);
    addVec(0, 1, C3, 1, 80'hBE0,      8'h00, 0, 4'd3);
    addVec(0, 1, C3, 1, 80'h17C,      8'h01, 0, 4'd3);
    addVec(0, 1, C3, 1, 80'h17C,      8'h01, 1, 4'd3);
    addVec(0, 0, C6, 0, 80'h17C,      8'h01, 1, 4'd3);
    // Loss of lock: three misses, one hit clears, then four misses drop lock.
    addVec(0, 1, C6, 1, 80'h17C,      8'h01, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 1, 4'd3);
    addVec(0, 1, C3, 1, 80'hBE0,      8'h00, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'h17C,      8'h01, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 1, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 0, 4'd3);
    addVec(0, 1, C6, 1, 80'hBE0,      8'h00, 0, 4'd6);
    addVec(0, 1, C6, 1, 80'h17C,      8'h01, 0, 4'd6);
    addVec(0, 1, C6, 1, 80'h17C,      8'h01, 1, 4'd6);
    // Reset wins over a valid word.
    addVec(1, 1, C3, 0, Z,            8'h00, 0, 4'd0);
    // Offset 0, RD+ comma in symbol 5.
    addVec(0, 1, S5, 1, Z,            8'h00, 0, 4'd0);
    addVec(0, 1, S5, 1, S5,           8'h20, 0, 4'd0);
    addVec(0, 1, S5, 1, S5,           8'h20, 0, 4'd0);
    addVec(0, 1, S5, 1, S5,           8'h20, 1, 4'd0);
    addVec(1, 0, Z,  0, Z,            8'h00, 0, 4'd0);
    // Re-seed in CHECK: two hits at 3, then offset 7 takes over.
    addVec(0, 1, C3, 1, Z,            8'h00, 0, 4'd0);
    addVec(0, 1, C3, 1, 80'hBE0,      8'h00, 0, 4'd3);
    addVec(0, 1, C7, 1, 80'h17C,      8'h01, 0, 4'd3);
    addVec(0, 1, C7, 1, 80'h17C0,     8'h00, 0, 4'd7);
    addVec(0, 1, C7, 1, 80'h17C,      8'h01, 0, 4'd7);
    addVec(0, 1, C7, 1, 80'h17C,      8'h01, 1, 4'd7);
    addVec(1, 0, Z,  0, Z,            8'h00, 0, 4'd0);
    // Gaps carry offset-6 garbage that must never reach prev.
    addVec(0, 1, C3, 1, Z,            8'h00, 0, 4'd0);
    addVec(0, 0, C6, 0, Z,            8'h00, 0, 4'd0);
    addVec(0, 1, C3, 1, 80'hBE0,      8'h00, 0, 4'd3);
    addVec(0, 0, C6, 0, 80'hBE0,      8'h00, 0, 4'd3);
    addVec(0, 1, C3, 1, 80'h17C,      8'h01, 0, 4'd3);
    addVec(0, 0, C6, 0, 80'h17C,      8'h01, 0, 4'd3);
    addVec(0, 0, C6, 0, 80'h17C,      8'h01, 0, 4'd3);
    addVec(0, 1, C3, 1, 80'h17C,      8'h01, 1, 4'd3);
    addVec(1, 1, C3, 0, Z,            8'h00, 0, 4'd0);
    addVec(0, 0, C3, 0, Z,            8'h00, 0, 4'd0);

    // Reset held three clocks with random valid data.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, {$urandom, $urandom, 16'($urandom)});
      checkOutput($sformatf("reset%0d", i), 1'b0, Z, 8'h00, 1'b0, 4'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].ea,
                  vecs[i].eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
